cr_hs_src_ctl: RTL and testbench

CR_HS_SRC_CTL -- requirements
Module: cr_hs_src_ctl

---
 rtl/cr_hs_pkg.sv | 20 ++
 rtl/cr_sync2_rh.sv | 27 ++
 rtl/cr_hs_src_ctl.sv | 183 ++++++++++++++++++
 tb/tb_cr_hs_src_ctl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_hs_pkg.sv
// Shared types for the 4-phase handshake source controller.
// Holds the controller state enum and the transfer-counter width.
package cr_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } hs_state_e;

    localparam int XFER_CNT_W = 16;

    // Transfer count advances modulo 2^XFER_CNT_W.
    function automatic logic [XFER_CNT_W-1:0] xfer_inc(
        input logic [XFER_CNT_W-1:0] cnt
    );
        return cnt + 1'b1;
    endfunction

endpackage

// File: rtl/cr_sync2_rh.sv
// Two-flop synchronizer, asynchronous active-high reset.
// Ports: clk, rst, i_d (async input), o_q (synchronized output).
module cr_sync2_rh #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/cr_hs_src_ctl.sv
// 4-phase request/acknowledge source controller toward a remote clock domain.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data local
// word offer; xreq/xdata registered request + word, xack async acknowledge;
// done completion pulse, xfer_cnt completed count; tmo_err sticky timeout
// flag, err_clr clears it.
module cr_hs_src_ctl
    import cr_hs_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  xreq,
    output logic [DATA_W-1:0]     xdata,
    input  logic                  xack,
    output logic                  done,
    output logic [XFER_CNT_W-1:0] xfer_cnt,
    output logic                  tmo_err,
    input  logic                  err_clr
);

    localparam int PH_W =
        (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);
    localparam logic [PH_W-1:0] PH_MAX =
        PH_W'(TMO_CYC);
    localparam logic [PH_W-1:0] PH_LAST =
        PH_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);
    localparam bit TMO_EN = (TMO_CYC > 0);

    hs_state_e             r_state;
    hs_state_e             w_state_nxt;
    logic                  r_xreq;
    logic                  w_xreq_nxt;
    logic [DATA_W-1:0]     r_xdata;
    logic                  r_done;
    logic                  w_done_nxt;
    logic [XFER_CNT_W-1:0] r_xfer_cnt;
    logic                  r_tmo;
    logic                  r_abort;
    logic                  w_abort_nxt;
    logic [PH_W-1:0]       r_ph;
    logic [PH_W-1:0]       w_ph_nxt;
    logic                  w_ack_s;
    logic                  w_tmo_hit;
    logic                  w_set_err;
    logic                  w_load;
    logic                  w_count;
    logic                  w_ph_restart;

    // Raw xack is only ever seen through this synchronizer.
    cr_sync2_rh #(
        .W (1)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .i_d (xack),
        .o_q (w_ack_s)
    );

    // The counter steps to TMO_CYC on this edge.
    assign w_tmo_hit = TMO_EN && (r_ph == PH_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_xreq_nxt   = r_xreq;
        w_done_nxt   = 1'b0;
        w_abort_nxt  = r_abort;
        w_set_err    = 1'b0;
        w_load       = 1'b0;
        w_count      = 1'b0;
        w_ph_restart = 1'b0;
        unique case (r_state)
            IDLE: begin
                // A stale ack_s=1 here is ignored.
                if (in_valid) begin
                    w_state_nxt = REQ;
                    w_xreq_nxt  = 1'b1;
                    w_load      = 1'b1;
                    w_abort_nxt = 1'b0;
                end
            end
            REQ: begin
                if (w_ack_s) begin
                    w_state_nxt = DROP;
                    w_xreq_nxt  = 1'b0;
                end else if (w_tmo_hit) begin
                    w_state_nxt = DROP;
                    w_xreq_nxt  = 1'b0;
                    w_set_err   = 1'b1;
                    w_abort_nxt = 1'b1;
                end
            end
            DROP: begin
                if (!w_ack_s) begin
                    w_state_nxt = IDLE;
                    w_abort_nxt = 1'b0;
                    // An aborted handshake never counts.
                    if (!r_abort) begin
                        w_done_nxt = 1'b1;
                        w_count    = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_set_err    = 1'b1;
                    w_abort_nxt  = 1'b1;
                    w_ph_restart = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_xreq_nxt  = 1'b0;
                w_abort_nxt = 1'b0;
            end
        endcase
    end

    // Phase counter: cleared on state change or DROP restart,
    // otherwise counts up and saturates at TMO_CYC.
    always_comb begin
        w_ph_nxt = r_ph;
        if ((w_state_nxt != r_state) || w_ph_restart) begin
            w_ph_nxt = '0;
        end else if (r_ph != PH_MAX) begin
            w_ph_nxt = r_ph + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_xreq  <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            r_ph    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_xreq  <= w_xreq_nxt;
            r_done  <= w_done_nxt;
            r_abort <= w_abort_nxt;
            r_ph    <= w_ph_nxt;
        end
    end

    // xdata only loads on acceptance, so it is stable
    // for the whole open handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xdata <= '0;
        end else if (w_load) begin
            r_xdata <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer_cnt <= '0;
        end else if (w_count) begin
            r_xfer_cnt <= xfer_inc(r_xfer_cnt);
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= 1'b0;
        end else if (w_set_err) begin
            r_tmo <= 1'b1;
        end else if (err_clr) begin
            r_tmo <= 1'b0;
        end
    end

    assign in_ready = (r_state == IDLE);
    assign xreq     = r_xreq;
    assign xdata    = r_xdata;
    assign done     = r_done;
    assign xfer_cnt = r_xfer_cnt;
    assign tmo_err  = r_tmo;

endmodule

// File: tb/tb_cr_hs_src_ctl.sv
// Directed bench for cr_hs_src_ctl.
// Immediate assertions at each check point.
module tb_cr_hs_src_ctl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        xreq;
    logic [31:0] xdata;
    logic        xack;
    logic        done;
    logic [15:0] xfer_cnt;
    logic        tmo_err;
    logic        err_clr;

    logic        loop_en;
    int          n_vec;
    int          n_err;
    logic [31:0] w [4];

    cr_hs_src_ctl #(
        .DATA_W  (32),
        .TMO_CYC (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .xreq     (xreq),
        .xdata    (xdata),
        .xack     (xack),
        .done     (done),
        .xfer_cnt (xfer_cnt),
        .tmo_err  (tmo_err),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remote side: ack mirrors request, changed on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (loop_en) xack = xreq;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, want);
        end
    endtask

    initial begin
        int  k;
        int  j;
        int  nreq;
        int  ndone;
        int  nbad;
        logic rdy;

        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        xack = 1'b0;
        err_clr = 1'b0;
        loop_en = 1'b0;
        w[0] = 32'h1111_1111;
        w[1] = 32'h2222_2222;
        w[2] = 32'h3333_3333;
        w[3] = 32'h4444_4444;

        // Reset state
        #3;
        chk("rst_xreq", 32'(xreq), 0);
        chk("rst_xdata", xdata, 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cnt", 32'(xfer_cnt), 0);
        chk("rst_tmo", 32'(tmo_err), 0);
        chk("rst_rdy", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("idle_rdy", 32'(in_ready), 1);

        // Single transfer, remote acks one cycle after xreq
        loop_en = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hA5A5_A5A5;
        step();
        chk("t1_xreq", 32'(xreq), 1);
        chk("t1_xdata", xdata, 32'hA5A5_A5A5);
        chk("t1_rdy", 32'(in_ready), 0);
        in_valid = 1'b0;
        in_data = '0;
        nreq = 1;
        ndone = 0;
        nbad = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (xreq) nreq++;
            if (done) ndone++;
            if (xdata !== 32'hA5A5_A5A5) nbad++;
        end
        chk("t1_req_cyc", 32'(nreq), 3);
        chk("t1_done", 32'(ndone), 1);
        chk("t1_stable", 32'(nbad), 0);
        chk("t1_cnt", 32'(xfer_cnt), 1);

        // Timeout in REQ with err_clr on the same edge
        loop_en = 1'b0;
        xack = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h3C3C_3C3C;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("t2_xreq_8", 32'(xreq), 1);
        chk("t2_tmo_pre", 32'(tmo_err), 0);
        err_clr = 1'b1;
        step();
        chk("t2_tmo_set", 32'(tmo_err), 1);
        chk("t2_xreq_off", 32'(xreq), 0);
        chk("t2_drop", 32'(in_ready), 0);
        chk("t2_done_a", 32'(done), 0);
        step();
        chk("t2_tmo_clr", 32'(tmo_err), 0);
        chk("t2_idle", 32'(in_ready), 1);
        chk("t2_done_b", 32'(done), 0);
        chk("t2_cnt", 32'(xfer_cnt), 1);
        err_clr = 1'b0;

        // Ack ignored in IDLE, then timeout in DROP
        xack = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("t3_idle_rdy", 32'(in_ready), 1);
        chk("t3_idle_xreq", 32'(xreq), 0);
        in_valid = 1'b1;
        in_data = 32'h0F0F_0F0F;
        step();
        chk("t3_xreq", 32'(xreq), 1);
        in_valid = 1'b0;
        step();
        chk("t3_drop_xreq", 32'(xreq), 0);
        k = 0;
        while (!tmo_err && k < 20) begin
            step();
            k++;
        end
        chk("t3_tmo", 32'(tmo_err), 1);
        chk("t3_tmo_lat", 32'(k), 8);
        chk("t3_in_drop", 32'(in_ready), 0);
        xack = 1'b0;
        k = 0;
        ndone = 0;
        while (!in_ready && k < 10) begin
            step();
            if (done) ndone++;
            k++;
        end
        chk("t3_exit_lat", 32'(k), 3);
        chk("t3_idle", 32'(in_ready), 1);
        chk("t3_no_done", 32'(ndone), 0);
        chk("t3_cnt", 32'(xfer_cnt), 1);

        // Counter wrap from 0xFFFF
        force dut.r_xfer_cnt = 16'hFFFF;
        #1;
        chk("t4_forced", 32'(xfer_cnt), 32'hFFFF);
        release dut.r_xfer_cnt;
        step();
        chk("t4_hold", 32'(xfer_cnt), 32'hFFFF);
        loop_en = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        step();
        in_valid = 1'b0;
        k = 0;
        while (!done && k < 12) begin
            step();
            k++;
        end
        chk("t4_done", 32'(done), 1);
        chk("t4_lat", 32'(k), 6);
        chk("t4_wrap", 32'(xfer_cnt), 0);
        chk("t4_xdata", xdata, 32'hDEAD_BEEF);
        step();
        chk("t4_pulse", 32'(done), 0);

        // Four back-to-back transfers, in_valid held
        j = 0;
        k = 0;
        ndone = 0;
        nbad = 0;
        in_valid = 1'b1;
        in_data = w[0];
        while ((j < 4 || xfer_cnt != 16'd4) && k < 60) begin
            rdy = in_ready;
            step();
            k++;
            if (done) ndone++;
            if (xreq && in_ready) nbad++;
            if (rdy && in_valid) begin
                chk("t5_word", xdata, w[j]);
                j++;
                if (j == 4) in_valid = 1'b0;
                else in_data = w[j];
            end
        end
        chk("t5_words", 32'(j), 4);
        chk("t5_cnt", 32'(xfer_cnt), 4);
        chk("t5_done", 32'(ndone), 4);
        chk("t5_rdy_low", 32'(nbad), 0);
        chk("t5_tmo_sticky", 32'(tmo_err), 1);

        // Reset asserted mid-REQ
        loop_en = 1'b0;
        xack = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h1234_5678;
        step();
        chk("t6_xreq", 32'(xreq), 1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_xreq_off", 32'(xreq), 0);
        chk("t6_xdata", xdata, 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_cnt", 32'(xfer_cnt), 0);
        chk("t6_tmo", 32'(tmo_err), 0);
        chk("t6_rdy", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("t6_rel_rdy", 32'(in_ready), 1);
        chk("t6_rel_xreq", 32'(xreq), 0);
        chk("t6_rel_done", 32'(done), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
